// File: rtl/k2_pkg.sv
// rtl/k2_pkg.sv - shared K2 types and sizing constants
package k2_pkg;

  localparam int K2_PC_BITS    = 4;
  localparam int K2_INSTR_BITS = 8;
  localparam int K2_PROG_DEPTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    RUN,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/k2_program_mem.sv
// rtl/k2_program_mem.sv - instruction storage, async clear, sync write, combinational read
module k2_program_mem #(
  parameter int ADDR_BITS = 4,
  parameter int BITS      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [BITS-1:0]      wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [BITS-1:0]      rdata
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [BITS-1:0] mem [DEPTH];

  // Clearing on rst guarantees a half-loaded program never survives a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/k2_program_loader.sv
// rtl/k2_program_loader.sv - K2 program loader FSM and instruction server
// Optional checksum byte after the program is built when CHECKSUM_EN is defined.
module k2_program_loader
  import k2_pkg::*;
#(
  parameter int ADDR_BITS = K2_PC_BITS,
  parameter int BITS      = K2_INSTR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 run_start,
  input  logic                 byte_valid,
  input  logic [BITS-1:0]      byte_data,
  output logic                 byte_ready,
  input  logic [ADDR_BITS-1:0] program_address,
  output logic [BITS-1:0]      instruction_data,
  output logic                 cpu_rst_n,
  output logic                 loading,
  output logic                 load_done,
  output logic                 load_error
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  loader_state_t        state, state_n;
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [BITS-1:0]      rdata;
  logic                 we, clr, done_n;
`ifdef CHECKSUM_EN
  logic [BITS-1:0]      sum;
`endif

  k2_program_mem #(
    .ADDR_BITS(ADDR_BITS),
    .BITS     (BITS)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(wr_ptr),
    .wdata(byte_data),
    .raddr(program_address),
    .rdata(rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    byte_ready = 1'b0;
    loading    = 1'b0;
    cpu_rst_n  = 1'b0;
    we         = 1'b0;
    clr        = 1'b0;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_n = LOAD;
          clr     = 1'b1;
        end else if (run_start) begin
          state_n = RUN;
        end
      end
      LOAD: begin
        loading = 1'b1;
        // A restart drops any byte offered alongside it.
        if (load_start) begin
          clr = 1'b1;
        end else begin
          byte_ready = 1'b1;
          if (byte_valid) begin
            we = 1'b1;
            if (wr_ptr == LAST_ADDR) begin
`ifdef CHECKSUM_EN
              state_n = CHECK;
`else
              state_n = RUN;
              done_n  = 1'b1;
`endif
            end
          end
        end
      end
`ifdef CHECKSUM_EN
      CHECK: begin
        loading = 1'b1;
        if (load_start) begin
          state_n = LOAD;
          clr     = 1'b1;
        end else begin
          byte_ready = 1'b1;
          if (byte_valid) begin
            if (byte_data == sum) begin
              state_n = RUN;
              done_n  = 1'b1;
            end else begin
              state_n = ERROR;
            end
          end
        end
      end
      ERROR: begin
        if (load_start) begin
          state_n = LOAD;
          clr     = 1'b1;
        end
      end
`endif
      RUN: begin
        cpu_rst_n = 1'b1;
        if (load_start) begin
          state_n = LOAD;
          clr     = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      load_done <= 1'b0;
`ifdef CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      load_done <= done_n;
      // The pointer wraps naturally to 0 on the final program byte.
      if (clr)     wr_ptr <= '0;
      else if (we) wr_ptr <= wr_ptr + 1'b1;
`ifdef CHECKSUM_EN
      if (clr)     sum <= '0;
      else if (we) sum <= sum + byte_data;
`endif
    end
  end

`ifdef CHECKSUM_EN
  assign load_error = (state == ERROR);
`else
  assign load_error = 1'b0;
`endif

  assign instruction_data = (state == RUN) ? rdata : '0;

endmodule

// File: tb/tb_k2_program_loader.sv
// tb/tb_k2_program_loader.sv - randomized self-checking bench for k2_program_loader
module tb_k2_program_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0;
  logic       run_start = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_ready;
  logic [3:0] program_address = 4'h0;
  logic [7:0] instruction_data;
  logic       cpu_rst_n;
  logic       loading;
  logic       load_done;
  logic       load_error;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_mem [16];
  logic [7:0] tx [16];
  int         m_ptr = 0;

  k2_program_loader dut (
    .clk             (clk),
    .rst             (rst),
    .load_start      (load_start),
    .run_start       (run_start),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .byte_ready      (byte_ready),
    .program_address (program_address),
    .instruction_data(instruction_data),
    .cpu_rst_n       (cpu_rst_n),
    .loading         (loading),
    .load_done       (load_done),
    .load_error      (load_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hEE;
    @(negedge clk);
    chk("ready_on_load_start", byte_ready, 0);
    @(posedge clk); #1;
    load_start = 1'b0;
    byte_valid = 1'b0;
    m_ptr = 0;
  endtask

  task automatic feed(input int n, input bit gaps);
    int acc = 0;
    int cyc = 0;
    while (acc < n && cyc < 400) begin
      byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_data  = byte_valid ? tx[acc] : 8'($urandom);
      run_start  = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      chk("ready_load", byte_ready, 1);
      chk("loading", loading, 1);
      chk("cpu_rst_load", cpu_rst_n, 0);
      if (byte_valid) begin
        m_mem[m_ptr] = tx[acc];
        m_ptr = (m_ptr + 1) % 16;
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    byte_valid = 1'b0;
    run_start  = 1'b0;
    chk("feed_bound", acc, n);
  endtask

  task automatic finish_load();
`ifdef CHECKSUM_EN
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 16; i++) s = s + m_mem[i];
    byte_valid = 1'b1;
    byte_data  = s;
    @(negedge clk);
    chk("ready_check", byte_ready, 1);
    @(posedge clk); #1;
`endif
    byte_valid      = 1'b1;
    byte_data       = 8'h5A;
    program_address = 4'd5;
    @(negedge clk);
    chk("load_done_pulse", load_done, 1);
    chk("cpu_rst_run", cpu_rst_n, 1);
    chk("loading_run", loading, 0);
    chk("ready_run", byte_ready, 0);
    chk("instr_addr5", instruction_data, m_mem[5]);
    @(posedge clk); #1;
    @(negedge clk);
    chk("load_done_once", load_done, 0);
    chk("ready_run2", byte_ready, 0);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic verify_mem(input bit running);
    int off = $urandom_range(0, 15);
    for (int i = 0; i < 16; i++) begin
      program_address = 4'((i + off) % 16);
      #2;
      chk("instr_read", instruction_data, running ? m_mem[(i + off) % 16] : 8'h00);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;

    #2;
    chk("rst_cpu_rst_n", cpu_rst_n, 0);
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_loading", loading, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_load_error", load_error, 0);
    verify_mem(1'b0);
    @(negedge clk);
    rst = 1'b0;
    byte_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_ready", byte_ready, 0);
    chk("idle_cpu_rst_n", cpu_rst_n, 0);
    chk("idle_instr", instruction_data, 0);
    @(posedge clk); #1;
    byte_valid = 1'b0;

    // Full load with a continuous stream.
    start_load();
    for (int i = 0; i < 16; i++) tx[i] = 8'(8'h10 + i);
    feed(16, 1'b0);
    finish_load();
    verify_mem(1'b1);

    // Randomized programs with gapped byte_valid, restarted from RUN.
    repeat (3) begin
      start_load();
      for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
      feed(16, 1'b1);
      finish_load();
      verify_mem(1'b1);
    end

    // Restart mid-load; the byte offered with load_start is dropped.
    start_load();
    for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
    feed(7, 1'b1);
    start_load();
    for (int i = 0; i < 16; i++) tx[i] = 8'(8'hA0 + i);
    feed(16, 1'b1);
    finish_load();
    verify_mem(1'b1);

    // Asynchronous reset mid-load wipes the memory.
    start_load();
    for (int i = 0; i < 16; i++) tx[i] = 8'($urandom | 1);
    feed(9, 1'b1);
    rst = 1'b1;
    #2;
    chk("arst_cpu_rst_n", cpu_rst_n, 0);
    chk("arst_byte_ready", byte_ready, 0);
    chk("arst_loading", loading, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_ptr = 0;
    @(posedge clk); #1;
    run_start = 1'b1;
    @(posedge clk); #1;
    run_start = 1'b0;
    @(negedge clk);
    chk("run_after_rst_cpu", cpu_rst_n, 1);
    chk("run_after_rst_done", load_done, 0);
    @(posedge clk); #1;
    verify_mem(1'b1);

`ifdef CHECKSUM_EN
    start_load();
    for (int i = 0; i < 16; i++) tx[i] = 8'h11;
    feed(16, 1'b0);
    finish_load();
    verify_mem(1'b1);

    start_load();
    feed(16, 1'b0);
    byte_valid = 1'b1;
    byte_data  = 8'h00;
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_flag", load_error, 1);
    chk("err_cpu_rst_n", cpu_rst_n, 0);
    chk("err_ready", byte_ready, 0);
    chk("err_no_done", load_done, 0);
    run_start = 1'b1;
    @(posedge clk); #1;
    run_start = 1'b0;
    @(negedge clk);
    chk("err_run_ignored", load_error, 1);
    chk("err_run_cpu", cpu_rst_n, 0);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    start_load();
    @(negedge clk);
    chk("err_cleared", load_error, 0);
    chk("err_reload", loading, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
    feed(16, 1'b1);
    finish_load();
    verify_mem(1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
